// File: rtl/call_scheduler.sv
// call_scheduler: floor-call button conditioning, pending-call latch and
// directional (SCAN-style) target selection for the movement controller.
module call_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       floor1,
    input  logic       floor2,
    input  logic       floor3,
    input  logic       door,
    input  logic       sos_mode,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] target_floor,
    output logic       target_valid,
    output logic       dir_up,
    output logic       dir_down
);

    localparam int unsigned N_FLOORS = 3;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned FLOOR_W  = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    logic [N_FLOORS-1:0] raw;
    logic [N_FLOORS-1:0] sync1;
    logic [N_FLOORS-1:0] sync2;
    logic [N_FLOORS-1:0] deb;
    logic [N_FLOORS-1:0] deb_d;
    logic [N_FLOORS-1:0] press;
    logic [N_FLOORS-1:0] pending;
    logic [CNT_W-1:0]    cnt [N_FLOORS];
    logic [FLOOR_W-1:0]  cur_floor;

    state_t              state;
    state_t              nxt_state;
    logic [FLOOR_W-1:0]  nxt_target;
    logic                nxt_valid;

    logic [FLOOR_W-1:0]  low_above;
    logic [FLOOR_W-1:0]  high_below;
    logic                any_above;
    logic                any_below;
    logic                at_cur;
    logic [FLOOR_W-1:0]  dist_up;
    logic [FLOOR_W-1:0]  dist_down;

    assign raw = {button3, button2, button1};

    // Two-flop synchroniser, stability-count debounce and registered press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < int'(N_FLOORS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < int'(N_FLOORS); i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Track the car position; ambiguous indicator patterns hold the last floor
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_floor <= FLOOR_W'(1);
        end else begin
            case ({floor3, floor2, floor1})
                3'b001:  cur_floor <= FLOOR_W'(1);
                3'b010:  cur_floor <= FLOOR_W'(2);
                3'b100:  cur_floor <= FLOOR_W'(3);
                default: cur_floor <= cur_floor;
            endcase
        end
    end

    // Pending-call latch: SOS flush, then serve-at-floor clear, then press set
    always_ff @(posedge clk) begin
        if (reset || sos_mode) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < int'(N_FLOORS); i++) begin
                if (door && (cur_floor == FLOOR_W'(i + 1))) begin
                    pending[i] <= 1'b0;
                end else if (press[i]) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    assign led1 = pending[0];
    assign led2 = pending[1];
    assign led3 = pending[2];

    // Nearest pending call above and below the car, and call at the car
    always_comb begin
        low_above  = '0;
        high_below = '0;
        any_above  = 1'b0;
        any_below  = 1'b0;
        at_cur     = 1'b0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            if (pending[i]) begin
                if ((FLOOR_W'(i + 1) > cur_floor) && !any_above) begin
                    low_above = FLOOR_W'(i + 1);
                    any_above = 1'b1;
                end
                if (FLOOR_W'(i + 1) < cur_floor) begin
                    high_below = FLOOR_W'(i + 1);
                    any_below  = 1'b1;
                end
                if (FLOOR_W'(i + 1) == cur_floor) begin
                    at_cur = 1'b1;
                end
            end
        end
        dist_up   = low_above - cur_floor;
        dist_down = cur_floor - high_below;
    end

    // Sweep decision: keep direction while calls remain ahead, else reverse or idle
    always_comb begin
        nxt_state  = state;
        nxt_target = '0;
        nxt_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (any_above && (!any_below || (dist_up <= dist_down))) begin
                    nxt_state  = UP;
                    nxt_target = low_above;
                    nxt_valid  = 1'b1;
                end else if (any_below) begin
                    nxt_state  = DOWN;
                    nxt_target = high_below;
                    nxt_valid  = 1'b1;
                end else if (at_cur) begin
                    nxt_target = cur_floor;
                    nxt_valid  = 1'b1;
                end
            end
            UP: begin
                if (any_above) begin
                    nxt_target = low_above;
                    nxt_valid  = 1'b1;
                end else if (at_cur) begin
                    nxt_target = cur_floor;
                    nxt_valid  = 1'b1;
                end else if (any_below) begin
                    nxt_state  = DOWN;
                    nxt_target = high_below;
                    nxt_valid  = 1'b1;
                end else begin
                    nxt_state  = IDLE;
                end
            end
            DOWN: begin
                if (any_below) begin
                    nxt_target = high_below;
                    nxt_valid  = 1'b1;
                end else if (at_cur) begin
                    nxt_target = cur_floor;
                    nxt_valid  = 1'b1;
                end else if (any_above) begin
                    nxt_state  = UP;
                    nxt_target = low_above;
                    nxt_valid  = 1'b1;
                end else begin
                    nxt_state  = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Scheduler state and registered target/direction outputs
    always_ff @(posedge clk) begin
        if (reset || sos_mode) begin
            state        <= IDLE;
            target_floor <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b0;
            dir_down     <= 1'b0;
        end else begin
            state        <= nxt_state;
            target_floor <= nxt_target;
            target_valid <= nxt_valid;
            dir_up       <= (nxt_state == UP);
            dir_down     <= (nxt_state == DOWN);
        end
    end

endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: directed vectors, corner sequences and random stimulus
// checked against a behavioural model of the call scheduler.
module tb_call_scheduler;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] b;
    logic [2:0] f;
    logic       door;
    logic       sos;
    logic       led1, led2, led3;
    logic [1:0] target_floor;
    logic       target_valid, dir_up, dir_down;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    call_scheduler #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .button1      (b[0]),
        .button2      (b[1]),
        .button3      (b[2]),
        .floor1       (f[0]),
        .floor2       (f[1]),
        .floor3       (f[2]),
        .door         (door),
        .sos_mode     (sos),
        .led1         (led1),
        .led2         (led2),
        .led3         (led3),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .dir_down     (dir_down)
    );

    // Behavioural model state
    bit [2:0] m_s1, m_s2, m_deb, m_deb_d, m_press, m_pend;
    bit [2:0] m_hist [DEB];
    int       m_cur, m_dir, m_tgt;

    typedef struct {
        logic       rst;
        logic [2:0] b;
        logic [2:0] f;
        logic       door;
        logic       sos;
        int         cyc;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [16];
    bit   bounce_pat [14] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};

    function automatic logic [7:0] dut_vec();
        return {led3, led2, led1, target_floor, target_valid, dir_up, dir_down};
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_pend, 2'(m_tgt), (m_tgt != 0), (m_dir == 1), (m_dir == -1)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        bit [2:0] deb_n;
        bit [2:0] pend_n;
        int       cur_n, dir_n, tgt_n, up_t, dn_t;
        bit       here, flip;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_d = '0; m_press = '0; m_pend = '0;
            for (int k = 0; k < int'(DEB); k++) m_hist[k] = '0;
            m_cur = 1; m_dir = 0; m_tgt = 0;
            return;
        end
        // debounced level flips once the last DEB synchronised samples all disagree
        for (int k = int'(DEB) - 1; k >= 1; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        deb_n = m_deb;
        for (int i = 0; i < 3; i++) begin
            flip = 1'b1;
            for (int k = 0; k < int'(DEB); k++)
                if (m_hist[k][i] == m_deb[i]) flip = 1'b0;
            if (flip) deb_n[i] = ~m_deb[i];
        end
        pend_n = m_pend;
        if (sos) pend_n = '0;
        else begin
            for (int i = 0; i < 3; i++) begin
                if (door && m_cur == i + 1) pend_n[i] = 1'b0;
                else if (m_press[i]) pend_n[i] = 1'b1;
            end
        end
        up_t = 0; dn_t = 0;
        for (int fl = m_cur + 1; fl <= 3; fl++) if (m_pend[fl-1] && up_t == 0) up_t = fl;
        for (int fl = m_cur - 1; fl >= 1; fl--) if (m_pend[fl-1] && dn_t == 0) dn_t = fl;
        here = m_pend[m_cur-1];
        if (m_dir == 0) begin
            if (up_t != 0 && dn_t != 0) dir_n = ((up_t - m_cur) <= (m_cur - dn_t)) ? 1 : -1;
            else if (up_t != 0) dir_n = 1;
            else if (dn_t != 0) dir_n = -1;
            else dir_n = 0;
        end else if (m_dir == 1) begin
            dir_n = (up_t != 0 || here) ? 1 : (dn_t != 0) ? -1 : 0;
        end else begin
            dir_n = (dn_t != 0 || here) ? -1 : (up_t != 0) ? 1 : 0;
        end
        if (dir_n == 1) tgt_n = (up_t != 0) ? up_t : m_cur;
        else if (dir_n == -1) tgt_n = (dn_t != 0) ? dn_t : m_cur;
        else tgt_n = here ? m_cur : 0;
        if (sos) begin dir_n = 0; tgt_n = 0; end
        cur_n = m_cur;
        if ($countones(f) == 1) cur_n = (f == 3'b001) ? 1 : (f == 3'b010) ? 2 : 3;
        m_press = m_deb & ~m_deb_d;
        m_deb_d = m_deb;
        m_deb   = deb_n;
        m_s2    = m_s1;
        m_s1    = b;
        m_pend  = pend_n;
        m_cur   = cur_n;
        m_dir   = dir_n;
        m_tgt   = tgt_n;
    endtask

    // One clock edge: update the model, then compare away from the edge
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic set_in(input logic r, input logic [2:0] bb, input logic [2:0] ff,
                          input logic d, input logic s);
        reset = r; b = bb; f = ff; door = d; sos = s;
    endtask

    initial begin
        int pos;
        int r;
        set_in(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        check("reset", dut_vec(), 8'h00);

        // press-to-LED latency and first target
        set_in(1'b0, 3'b100, 3'b001, 1'b0, 1'b0);
        repeat (7) tick();
        check("lat_early", {7'd0, led3}, 8'd0);
        tick();
        check("lat_led3", {7'd0, led3}, 8'd1);
        tick();
        check("lat_target", dut_vec(), 8'b100_11_1_1_0);
        b = 3'b000;

        // directed vectors: sweep reversal, clear-wins, SOS flush
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2,  8'b000_00_0_0_0};
        tbl[1]  = '{1'b0, 3'b101, 3'b010, 1'b0, 1'b0, 8,  8'b101_00_0_0_0};
        tbl[2]  = '{1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1,  8'b101_11_1_1_0};
        tbl[3]  = '{1'b0, 3'b000, 3'b100, 1'b1, 1'b0, 1,  8'b101_11_1_1_0};
        tbl[4]  = '{1'b0, 3'b000, 3'b100, 1'b1, 1'b0, 1,  8'b001_11_1_1_0};
        tbl[5]  = '{1'b0, 3'b000, 3'b100, 1'b1, 1'b0, 1,  8'b001_01_1_0_1};
        tbl[6]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1,  8'b000_00_0_0_0};
        tbl[7]  = '{1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 10, 8'b000_00_0_0_0};
        tbl[8]  = '{1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 6,  8'b000_00_0_0_0};
        tbl[9]  = '{1'b0, 3'b110, 3'b001, 1'b0, 1'b0, 8,  8'b110_00_0_0_0};
        tbl[10] = '{1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1,  8'b110_10_1_1_0};
        tbl[11] = '{1'b0, 3'b000, 3'b001, 1'b0, 1'b1, 1,  8'b000_00_0_0_0};
        tbl[12] = '{1'b0, 3'b001, 3'b001, 1'b0, 1'b1, 10, 8'b000_00_0_0_0};
        tbl[13] = '{1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 6,  8'b000_00_0_0_0};
        tbl[14] = '{1'b0, 3'b100, 3'b001, 1'b0, 1'b0, 8,  8'b100_00_0_0_0};
        tbl[15] = '{1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1,  8'b100_11_1_1_0};
        for (int v = 0; v < 16; v++) begin
            set_in(tbl[v].rst, tbl[v].b, tbl[v].f, tbl[v].door, tbl[v].sos);
            repeat (tbl[v].cyc) tick();
            check($sformatf("vec%0d", v), dut_vec(), tbl[v].exp);
        end

        // bounce: no stable run reaches the debounce length
        set_in(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            b[1] = bounce_pat[i];
            tick();
            check("bounce", {7'd0, led2}, 8'd0);
        end
        b[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bounce_tail", {7'd0, led2}, 8'd0);
        end

        // floor-indicator glitch holds position, then reset mid-sweep
        set_in(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 3'b010, 3'b001, 1'b0, 1'b0);
        repeat (8) tick();
        check("g_led2", dut_vec(), 8'b010_00_0_0_0);
        b = 3'b000;
        tick();
        check("g_up", dut_vec(), 8'b010_10_1_1_0);
        f = 3'b011; door = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("g_hold", dut_vec(), 8'b010_10_1_1_0);
        end
        f = 3'b100; door = 1'b0;
        tick();
        check("g_move1", dut_vec(), 8'b010_10_1_1_0);
        tick();
        check("g_move2", dut_vec(), 8'b010_10_1_0_1);
        set_in(1'b1, 3'b111, 3'b111, 1'b1, 1'b0);
        tick();
        check("reset_mid", dut_vec(), 8'h00);

        // random traffic against the model
        set_in(1'b1, 3'b000, 3'b001, 1'b0, 1'b0);
        tick();
        pos = 1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
            if ($urandom_range(0, 9) == 0) pos = $urandom_range(1, 3);
            r = $urandom_range(0, 19);
            if (r == 0) f = 3'b000;
            else if (r == 1) f = 3'($urandom_range(0, 7));
            else f = 3'(1 << (pos - 1));
            door = ($urandom_range(0, 3) == 0);
            if (sos) sos = ($urandom_range(0, 3) != 0);
            else sos = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/call_scheduler.md
Name: call_scheduler

Overview:
- Upstream stage of the elevator movement controller.
- Synchronises and debounces the three raw floor-call buttons, latches pending calls, and drives the call LEDs.
- Runs a directional (SCAN-style) scheduler that gives the movement block one target floor at a time.
- Clears a call once the car is at that floor with the door open. Flushes all calls while SOS mode is active.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable clk cycles required before a synchronised button level is accepted (legal range 1..255)

Ports:
clk  input  1  system clock (divided clock from the frequency block); all logic rises on this edge
reset  input  1  synchronous, active-high reset
button1  input  1  raw floor-1 call button, active high, asynchronous
button2  input  1  raw floor-2 call button, active high, asynchronous
button3  input  1  raw floor-3 call button, active high, asynchronous
floor1  input  1  car-at-floor-1 indicator from movement
floor2  input  1  car-at-floor-2 indicator from movement
floor3  input  1  car-at-floor-3 indicator from movement
door  input  1  door-open indicator from movement
sos_mode  input  1  emergency active, from the emergency block
led1  output  1  floor-1 call pending
led2  output  1  floor-2 call pending
led3  output  1  floor-3 call pending
target_floor  output  2  next floor to serve: 1, 2 or 3; 0 means none
target_valid  output  1  target_floor is meaningful
dir_up  output  1  scheduler sweep direction is up
dir_down  output  1  scheduler sweep direction is down

Behaviour:
- Reset values:
  - All outputs registered and 0.
  - Sync flops 0; debounced levels 0; debounce counters 0.
  - Current-floor register = 1; state = IDLE.
- Synchroniser: two flops per button; s2 is the synchronised level.
- Debounce, per button:
  - While s2 == debounced level, the counter is held at 0.
  - While s2 != debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and s2 still differs, the debounced level toggles on the next edge and the counter clears.
  - Any bounce back to the debounced level clears the counter.
- Press event: one-cycle pulse on a debounced 0->1 edge. Release events do nothing.
- Latency: ledN rises exactly DEBOUNCE_CYCLES+3 cycles after the first edge at which the raw button is sampled high, provided the input stays high.
- Current floor:
  - Loaded from floor1..3 only when exactly one of them is high.
  - Zero or multiple high indicators hold the previous value (car between floors or glitch).
- Pending set/clear, each cycle, in priority order:
  1. sos_mode = 1: all pending bits clear and press events are discarded.
  2. A pending bit N clears when current floor == N and door = 1. A press on floor N under the same condition is ignored (clear wins).
  3. Otherwise a press event on N sets pending N. A press on an already-pending floor has no effect.
- led1..3 mirror the pending register directly: no extra delay, same-cycle register.
- Scheduler FSM: states IDLE, UP, DOWN. It evaluates the pending register as updated in the previous cycle.
- IDLE:
  - No pending: stay in IDLE; target_valid = 0, target_floor = 0, dir_up = dir_down = 0.
  - Pending above only: go to UP. Pending below only: go to DOWN.
  - Pending both above and below: nearest wins; on a tie (current = 2, calls at 1 and 3) go to UP.
  - Pending only at the current floor: target = current floor, target_valid = 1, stay in IDLE.
- UP:
  - target = lowest pending floor strictly above current.
  - If none above: go to DOWN if any pending below, otherwise go to IDLE.
  - A pending call at the current floor while in UP is served (target = current) before leaving UP.
- DOWN: mirror of UP, using the highest pending floor strictly below current.
- Direction outputs: dir_up = (state == UP), dir_down = (state == DOWN). They are never both 1.
- target_floor and target_valid update one cycle after the pending or current-floor change that causes them.
- While sos_mode = 1: state is forced to IDLE and outputs go to none/0 on the next edge.
- Reset asserted mid-sweep returns to the reset values on the next edge, regardless of the other inputs.

Test Plan:
1. DEBOUNCE_CYCLES = 4, reset, raw button3 held high, car at floor1, door = 0 -> led3 = 1 exactly 7 cycles after button3 is first sampled high; the next cycle target_floor = 3, target_valid = 1, dir_up = 1.
2. button2 pulsed high for 2 cycles then low, with bounce glitches -> led2 never asserts; counter restarts on each glitch.
3. Car at floor2, calls at floor1 and floor3 latched simultaneously -> state UP, target_floor = 3. After floor3 + door = 1, led3 clears and the next target is 1 with dir_down = 1.
4. Car at floor1, door = 1, button1 pressed -> led1 stays 0 and target_valid stays 0.
5. Calls at floors 2 and 3 pending, sos_mode raised -> led1..3 = 0 and target_valid = 0 on the next edge; presses during SOS ignored; after SOS drops, a new press is accepted normally.
6. floor1 and floor2 both high (glitch) while at floor1, then only floor3 high -> current floor stays 1 during the glitch, then becomes 3; reset asserted mid-sweep -> all outputs 0 on the next edge.
